countdown_timer_clear_clock: RTL
================================

// Module: countdown_timer_clear_clock
// PURPOSE
//  Loadable down-counter/timer; complements the up-counter with clear.
//  Counts a loaded value down to zero and flags expiry with a one-cycle done pulse.
//  Supports pause/resume and optional periodic auto-reload.
//  Serves as the timeout/interval generator beside the up-counters in the data_flow blocks.
// PARAMETERS
//  WIDTH  4  counter width in bits; Q, load_value and the reload register are WIDTH wide
// PORTS
//  clock        in   1      single clock; all state updates on rising edge
//  clear        in   1      reset, synchronous, active-high
//  load         in   1      load load_value into Q and reload register
//  load_value   in   WIDTH  value captured on load
//  start        in   1      begin countdown
//  pause        in   1      level: hold count while high
//  auto_reload  in   1      level: on expiry reload and keep running
//  Q            out  WIDTH  current count (registered)
//  busy         out  1      high in RUN or PAUSED
//  done         out  1      registered one-cycle expiry pulse
//  zero         out  1      combinational (Q == 0)
// BEHAVIOUR
//  Reset: clear=1 at a rising edge -> Q=0, reload_reg=0, state IDLE, done=0.
//   Then busy=0 and zero=1. clear overrides all other inputs, in any state, including mid-count.
//  States: IDLE, RUN, PAUSED, EXPIRED. busy=1 only in RUN/PAUSED.
//  done=0 on every edge unless an expiry event below sets it.
//  IDLE/EXPIRED + load=1 -> Q<=load_value, reload_reg<=load_value, state IDLE.
//   start is ignored on that edge (load wins).
//  IDLE + start=1, load=0:
//   Q!=0 -> RUN, Q unchanged.
//   Q==0 -> EXPIRED, done<=1.
//  EXPIRED + start=1, load=0:
//   reload_reg!=0 -> Q<=reload_reg, RUN.
//   reload_reg==0 -> stay EXPIRED, done<=1.
//  RUN, pause=0:
//   Q>1 -> Q<=Q-1.
//   Q==1 and auto_reload=1 and reload_reg!=0 -> Q<=reload_reg, done<=1, stay RUN.
//   Q==1 otherwise -> Q<=0, done<=1, EXPIRED.
//  RUN, pause=1 -> PAUSED; Q holds, no decrement on that edge.
//  PAUSED, pause=1 -> hold. PAUSED, pause=0 -> RUN; no decrement on that edge.
//  load and start are ignored in RUN and PAUSED.
//  Latency: start at edge N enters RUN; first decrement at edge N+1.
//   Value V reaches Q=0 with done=1 at edge N+V.
//  Auto-reload period = reload_reg cycles; done pulses once per period.
//   Q sequence is V..1, V..1 and never shows 0.
//  Arithmetic: unsigned, WIDTH bits. Q never wraps below 0 or above 2^WIDTH-1.
//   load_value of all-ones is valid.
//  auto_reload is sampled only at the Q==1 edge. Changing it mid-count is legal.
// TESTING
//  T1 clear; load 10; start -> Q 10,9..1,0.
//   done=1 only at edge start+10; then EXPIRED, busy=0, zero=1.
//  T2 load 3, auto_reload=1, start -> Q 3,2,1,3,2,1,3.
//   done=1 on each 1->3 edge (every 3 cycles); busy stays 1.
//  T3 load 8, start, pause=1 for 4 cycles when Q=5 -> Q holds 5 for 5 edges.
//   Then 4..0 resumes; total expiry at start+8+5.
//  T4 load 12, start, clear=1 at Q=7 -> next edge Q=0, busy=0, done=0, IDLE.
//   A later start gives an immediate done.
//  T5 in RUN at Q=6, load=1 with load_value=2 -> ignored, Q=5.
//   In IDLE, load+start same edge -> Q=load_value, still IDLE.
//  T6 load 15 (all ones), run to expiry; restart from EXPIRED via start.
//   Q reloads 15 and counts down again with no wrap.

Source files
------------

// File: rtl/countdown_timer_clear_clock.sv
// Loadable down-counter with pause, auto-reload and a registered one-cycle expiry pulse.
// Latency: start at edge N enters RUN, first decrement at N+1, value V expires at edge N+V; no backpressure.
module countdown_timer_clear_clock #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] reload_reg;

    always_ff @(posedge clock) begin
        if (clear) begin
            Q          <= '0;
            reload_reg <= '0;
            state      <= IDLE;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        Q          <= load_value;
                        reload_reg <= load_value;
                    end else if (start) begin
                        if (Q != '0) begin
                            state <= RUN;
                        end else begin
                            state <= EXPIRED;
                            done  <= 1'b1;
                        end
                    end
                end
                EXPIRED: begin
                    if (load) begin
                        Q          <= load_value;
                        reload_reg <= load_value;
                        state      <= IDLE;
                    end else if (start) begin
                        if (reload_reg != '0) begin
                            Q     <= reload_reg;
                            state <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state <= PAUSED;
                    end else if (Q > ONE) begin
                        Q <= Q - ONE;
                    end else if (auto_reload && reload_reg != '0) begin
                        // Periodic mode jumps straight from 1 back to the reload value, so Q never shows 0.
                        Q    <= reload_reg;
                        done <= 1'b1;
                    end else begin
                        Q     <= '0;
                        done  <= 1'b1;
                        state <= EXPIRED;
                    end
                end
                PAUSED: begin
                    if (!pause) begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN) || (state == PAUSED);
    assign zero = (Q == '0);

endmodule
